br_eval: RTL and testbench

- Condition-code and branch-enable stage wrapped around the LC-3 NZP register.
- Upstream role: derives the 3-bit N/Z/P code from the CPU bus value. That code feeds the NZP register's load input.
- Downstream role: consumes the registered N/Z/P code and IR[11:9] to produce the registered BEN flag used by the control FSM.
- Resolves BRnzp as taken or not taken with a one-shot strobe, so the FSM can load the PC.

---
 rtl/lc3_pkg.sv | 16 +
 rtl/cc_gen.sv | 30 +++
 rtl/br_eval.sv | 103 ++++++++++
 tb/tb_br_eval.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: BEN evaluation states and N/Z/P condition-code encodings.
package lc3_pkg;

  typedef enum logic [0:0] {
    BE_IDLE  = 1'b0,
    BE_ARMED = 1'b1
  } ben_state_t;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N   = 3'b100;
  localparam nzp_t NZP_Z   = 3'b010;
  localparam nzp_t NZP_P   = 3'b001;
  localparam nzp_t NZP_RST = 3'b000;

endpackage

// File: rtl/cc_gen.sv
// Combinational condition-code generator: classifies a two's-complement bus value
// as negative, zero or positive, producing a one-hot {N,Z,P} code.
module cc_gen
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] bus,
  output logic [2:0]        nzp
);

  logic neg_s;
  logic zero_s;

  assign neg_s  = bus[DATA_W-1];
  assign zero_s = (bus == {DATA_W{1'b0}});

  // One-hot classification; the sign bit takes priority so exactly one bit is set.
  always_comb begin
    nzp = NZP_RST;
    if (neg_s) begin
      nzp = NZP_N;
    end else if (zero_s) begin
      nzp = NZP_Z;
    end else begin
      nzp = NZP_P;
    end
  end

endmodule

// File: rtl/br_eval.sv
// Condition-code and branch-enable stage around the LC-3 NZP register.
// Optional branch statistics counters are enabled with the BR_STATS_EN macro.
module br_eval
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus,
  output logic [2:0]        nzp_next,
  input  logic [2:0]        nzp_q,
  input  logic [2:0]        ir_nzp,
  input  logic              ld_ben,
  input  logic              br_chk,
  output logic              ben,
  output logic              ben_valid,
  output logic              br_taken,
  output logic              stale_chk,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  ben_state_t state_r;
  logic       ben_r;
  logic       resolve_s;

  cc_gen #(
    .DATA_W (DATA_W)
  ) u_cc_gen (
    .bus (bus),
    .nzp (nzp_next)
  );

  // Strobe decode: a check in ARMED resolves against the old BEN even if ld_ben coincides.
  always_comb begin
    resolve_s = 1'b0;
    br_taken  = 1'b0;
    stale_chk = 1'b0;
    if (reset) begin
      resolve_s = 1'b0;
    end else if (br_chk) begin
      case (state_r)
        BE_ARMED: begin
          resolve_s = 1'b1;
          br_taken  = ben_r;
        end
        BE_IDLE: begin
          stale_chk = 1'b1;
        end
        default: begin
          stale_chk = 1'b0;
        end
      endcase
    end else begin
      resolve_s = 1'b0;
    end
  end

  // BEN capture FSM; ld_ben wins over the IDLE return so a same-cycle reload stays ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= BE_IDLE;
      ben_r   <= 1'b0;
    end else if (ld_ben) begin
      state_r <= BE_ARMED;
      ben_r   <= |(ir_nzp & nzp_q);
    end else if (resolve_s) begin
      state_r <= BE_IDLE;
    end
  end

  assign ben       = ben_r;
  assign ben_valid = (state_r == BE_ARMED);

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;

  // Saturating statistics counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_r    <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (resolve_s && (br_cnt_r != {CNT_W{1'b1}})) begin
        br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (br_taken && (taken_cnt_r != {CNT_W{1'b1}})) begin
        taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign br_count    = br_cnt_r;
  assign taken_count = taken_cnt_r;
`else
  assign br_count    = {CNT_W{1'b0}};
  assign taken_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_br_eval.sv
// Directed self-checking bench for br_eval; counter checks adapt to BR_STATS_EN.
module tb_br_eval;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] bus;
  logic [2:0]        nzp_next;
  logic [2:0]        nzp_q;
  logic [2:0]        ir_nzp;
  logic              ld_ben;
  logic              br_chk;
  logic              ben;
  logic              ben_valid;
  logic              br_taken;
  logic              stale_chk;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  int checks = 0;
  int errors = 0;

  br_eval #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .nzp_next    (nzp_next),
    .nzp_q       (nzp_q),
    .ir_nzp      (ir_nzp),
    .ld_ben      (ld_ben),
    .br_chk      (br_chk),
    .ben         (ben),
    .ben_valid   (ben_valid),
    .br_taken    (br_taken),
    .stale_chk   (stale_chk),
    .br_count    (br_count),
    .taken_count (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Arm with a given nzp_q/ir_nzp, then resolve on the next cycle.
  task automatic do_branch(input logic [2:0] nq, input logic [2:0] ir);
    nzp_q = nq; ir_nzp = ir; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0; br_chk = 1'b1;
    tick();
    br_chk = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ben", {15'd0, ben}, 16'd0);
    chk("rst_valid", {15'd0, ben_valid}, 16'd0);
    chk("rst_taken", {15'd0, br_taken}, 16'd0);
    chk("rst_stale", {15'd0, stale_chk}, 16'd0);
    chk("rst_brcnt", {12'd0, br_count}, 16'd0);
    chk("rst_tkcnt", {12'd0, taken_count}, 16'd0);
  endtask

  task automatic test_cc();
    logic [15:0] vec [5];
    logic [2:0]  expv [5];
    vec[0] = 16'h8000; expv[0] = 3'b100;
    vec[1] = 16'h0000; expv[1] = 3'b010;
    vec[2] = 16'h7FFF; expv[2] = 3'b001;
    vec[3] = 16'hFFFF; expv[3] = 3'b100;
    vec[4] = 16'h0001; expv[4] = 3'b001;
    for (int i = 0; i < 5; i++) begin
      bus = vec[i];
      #1;
      checks++;
      if (nzp_next !== expv[i]) begin
        errors++;
        $display("FAIL cc_%0h: got %b expected %b", vec[i], nzp_next, expv[i]);
      end
    end
  endtask

  task automatic test_taken();
    nzp_q = 3'b010; ir_nzp = 3'b011; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    chk("tk_ben", {15'd0, ben}, 16'd1);
    chk("tk_valid", {15'd0, ben_valid}, 16'd1);
    chk("tk_pre_taken", {15'd0, br_taken}, 16'd0);
    br_chk = 1'b1;
    #1;
    chk("tk_taken", {15'd0, br_taken}, 16'd1);
    chk("tk_stale", {15'd0, stale_chk}, 16'd0);
    tick();
    br_chk = 1'b0;
    #1;
    chk("tk_valid_after", {15'd0, ben_valid}, 16'd0);
    chk("tk_ben_hold", {15'd0, ben}, 16'd1);
    chk("tk_taken_after", {15'd0, br_taken}, 16'd0);
  endtask

  task automatic test_not_taken();
    nzp_q = 3'b001; ir_nzp = 3'b110; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    chk("nt_ben", {15'd0, ben}, 16'd0);
    chk("nt_valid", {15'd0, ben_valid}, 16'd1);
    br_chk = 1'b1;
    #1;
    chk("nt_taken", {15'd0, br_taken}, 16'd0);
    tick();
    br_chk = 1'b0;
    chk("nt_valid_after", {15'd0, ben_valid}, 16'd0);
    // NOP branch: ir_nzp = 000 never enables, whatever the condition code.
    nzp_q = 3'b111; ir_nzp = 3'b000; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    chk("nop_ben", {15'd0, ben}, 16'd0);
    br_chk = 1'b1;
    #1;
    chk("nop_taken", {15'd0, br_taken}, 16'd0);
    tick();
    br_chk = 1'b0;
  endtask

  task automatic test_stale();
    br_chk = 1'b1;
    #1;
    chk("st_stale", {15'd0, stale_chk}, 16'd1);
    chk("st_taken", {15'd0, br_taken}, 16'd0);
    tick();
    br_chk = 1'b0;
    #1;
    chk("st_valid", {15'd0, ben_valid}, 16'd0);
    chk("st_stale_off", {15'd0, stale_chk}, 16'd0);
  endtask

  task automatic test_back_to_back();
    nzp_q = 3'b100; ir_nzp = 3'b100; ld_ben = 1'b1;
    tick();
    chk("bb_armed_ben", {15'd0, ben}, 16'd1);
    ir_nzp = 3'b011; br_chk = 1'b1;
    #1;
    chk("bb_taken", {15'd0, br_taken}, 16'd1);
    chk("bb_stale", {15'd0, stale_chk}, 16'd0);
    tick();
    ld_ben = 1'b0; br_chk = 1'b0;
    chk("bb_valid", {15'd0, ben_valid}, 16'd1);
    chk("bb_new_ben", {15'd0, ben}, 16'd0);
    br_chk = 1'b1;
    tick();
    br_chk = 1'b0;
    // Simultaneous strobes from IDLE: stale pulse and a fresh capture.
    nzp_q = 3'b001; ir_nzp = 3'b001; ld_ben = 1'b1; br_chk = 1'b1;
    #1;
    chk("bbi_stale", {15'd0, stale_chk}, 16'd1);
    chk("bbi_taken", {15'd0, br_taken}, 16'd0);
    tick();
    ld_ben = 1'b0; br_chk = 1'b0;
    chk("bbi_valid", {15'd0, ben_valid}, 16'd1);
    chk("bbi_ben", {15'd0, ben}, 16'd1);
    br_chk = 1'b1;
    tick();
    br_chk = 1'b0;
  endtask

  task automatic test_reset_armed();
    nzp_q = 3'b010; ir_nzp = 3'b010; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    reset = 1'b1; br_chk = 1'b1;
    #1;
    chk("ra_taken", {15'd0, br_taken}, 16'd0);
    chk("ra_stale", {15'd0, stale_chk}, 16'd0);
    tick();
    reset = 1'b0; br_chk = 1'b0;
    chk("ra_ben", {15'd0, ben}, 16'd0);
    chk("ra_valid", {15'd0, ben_valid}, 16'd0);
    nzp_q = 3'b000; ir_nzp = 3'b111; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    chk("ra_nzp0_ben", {15'd0, ben}, 16'd0);
    br_chk = 1'b1;
    #1;
    chk("ra_nzp0_taken", {15'd0, br_taken}, 16'd0);
    tick();
    br_chk = 1'b0;
  endtask

  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_branch(3'b100, 3'b100);
    do_branch(3'b001, 3'b110);
    do_branch(3'b010, 3'b111);
`ifdef BR_STATS_EN
    chk("stat_br3", {12'd0, br_count}, 16'd3);
    chk("stat_tk2", {12'd0, taken_count}, 16'd2);
`else
    chk("stat_br_tied", {12'd0, br_count}, 16'd0);
    chk("stat_tk_tied", {12'd0, taken_count}, 16'd0);
`endif
    for (int i = 0; i < 20; i++) begin
      do_branch(3'b001, 3'b001);
    end
`ifdef BR_STATS_EN
    chk("stat_br_sat", {12'd0, br_count}, 16'h000F);
    chk("stat_tk_sat", {12'd0, taken_count}, 16'h000F);
`else
    chk("stat_br_tied2", {12'd0, br_count}, 16'd0);
    chk("stat_tk_tied2", {12'd0, taken_count}, 16'd0);
`endif
  endtask

  initial begin
    reset = 1'b0; bus = 16'h0000; nzp_q = 3'b000; ir_nzp = 3'b000;
    ld_ben = 1'b0; br_chk = 1'b0;
    test_reset();
    test_cc();
    test_taken();
    test_not_taken();
    test_stale();
    test_back_to_back();
    test_reset_armed();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
